counter_nch: RTL

Parametrised multi-channel down-counter/timer peripheral for the MIO bus, generalising the fixed three-channel counter block. CH independent channels of WIDTH bits each count on per-channel synchronous tick enables (driven from `clkdiv` bits), in one-shot, periodic or square-wave mode. The block drives per-channel outputs and a maskable sticky interrupt to the CPU `INT` input. Counter values, control and status are readable through a registered readback port.

---
 rtl/counter_nch_if.sv | 14 +
 rtl/counter_nch.sv | 117 +++++++++++
 2 files changed

// File: rtl/counter_nch_if.sv
// MIO bus port of the multi-channel counter: write strobe, register select,
// write data and registered readback.
interface counter_nch_if #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
);
  logic             counter_we;
  logic [SEL_W-1:0] counter_ch;
  logic [WIDTH-1:0] counter_val;
  logic [WIDTH-1:0] counter_out;

  modport master (output counter_we, counter_ch, counter_val, input counter_out);
  modport slave  (input counter_we, counter_ch, counter_val, output counter_out);
endinterface

// File: rtl/counter_nch.sv
// CH-channel down-counter/timer (one-shot, periodic, square) on the MIO bus.
// Define COUNTER_NCH_IRQ_EN to build the ien/st registers, status address and irq.
module counter_nch #(
  parameter int CH    = 3,
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] tick,
  counter_nch_if.slave  bus,
  output logic [CH-1:0] cnt_out,
  output logic          irq
);

  typedef enum logic [1:0] {
    MODE_OFF      = 2'b00,
    MODE_ONESHOT  = 2'b01,
    MODE_PERIODIC = 2'b10,
    MODE_SQUARE   = 2'b11
  } mode_e;

  logic [WIDTH-1:0] reload [CH];
  logic [WIDTH-1:0] count  [CH];
  mode_e            mode   [CH];
  logic [CH-1:0]    ien;
  logic [CH-1:0]    st;

  logic [CH-1:0]    wr_ch;
  logic             wr_ctrl;
  logic [CH-1:0]    dec;
  logic [CH-1:0]    evt;
  logic [WIDTH-1:0] rd;

  always_comb begin
    wr_ctrl = bus.counter_we && (bus.counter_ch == SEL_W'(CH));
    for (int unsigned i = 0; i < CH; i++) begin
      wr_ch[i] = bus.counter_we && (bus.counter_ch == SEL_W'(i));
      // A channel write takes priority over a tick in the same cycle.
      dec[i]   = tick[i] && (mode[i] != MODE_OFF) && (count[i] != '0) && !wr_ch[i];
      evt[i]   = dec[i] && (count[i] == WIDTH'(1));
    end
  end

  always_comb begin
    rd = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (bus.counter_ch == SEL_W'(i)) rd = count[i];
    end
    if (bus.counter_ch == SEL_W'(CH)) begin
      for (int unsigned i = 0; i < CH; i++) rd[2*i +: 2] = mode[i];
      rd[2*CH +: CH] = ien;
    end
    if (bus.counter_ch == SEL_W'(CH + 1)) rd[CH-1:0] = st;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < CH; i++) begin
        reload[i] <= '0;
        count[i]  <= '0;
        mode[i]   <= MODE_OFF;
      end
      cnt_out         <= '0;
      bus.counter_out <= '0;
    end else begin
      bus.counter_out <= rd;
      for (int unsigned i = 0; i < CH; i++) begin
        if (wr_ch[i]) begin
          reload[i]  <= bus.counter_val;
          count[i]   <= bus.counter_val;
          cnt_out[i] <= 1'b0;
        end else begin
          if (dec[i]) begin
            if (evt[i] && mode[i] != MODE_ONESHOT) count[i] <= reload[i];
            else                                   count[i] <= count[i] - WIDTH'(1);
          end
          // Output rule uses the pre-write mode, so a same-cycle control write applies next cycle.
          case (mode[i])
            MODE_ONESHOT:  if (evt[i]) cnt_out[i] <= 1'b1;
            MODE_PERIODIC: cnt_out[i] <= evt[i];
            MODE_SQUARE:   if (evt[i]) cnt_out[i] <= ~cnt_out[i];
            default:       ;
          endcase
        end
        if (wr_ctrl) mode[i] <= mode_e'(bus.counter_val[2*i +: 2]);
      end
    end
  end

`ifdef COUNTER_NCH_IRQ_EN
  logic          wr_stat;
  logic [CH-1:0] clr;

  always_comb begin
    wr_stat = bus.counter_we && (bus.counter_ch == SEL_W'(CH + 1));
    clr     = wr_stat ? bus.counter_val[CH-1:0] : '0;
  end

  // Event set beats a same-cycle write-1-to-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ien <= '0;
      st  <= '0;
    end else begin
      if (wr_ctrl) ien <= bus.counter_val[2*CH +: CH];
      st <= (st & ~clr) | evt;
    end
  end
`else
  assign ien = '0;
  assign st  = '0;
`endif

  assign irq = |(st & ien);

endmodule
